// File: rtl/dmem_responder.sv
// dmem_responder: single-port 128 x 32-bit data memory with a fixed-latency
// request/response protocol.
//
// Handshake: in IDLE a low CEN at a rising edge captures A, D and WEN. The
// responder then waits LATENCY cycles (WAIT) and performs the array access on
// the edge entering RESP. ready is high for exactly the one RESP cycle.
// Requests arriving in WAIT or RESP are ignored. busy is high whenever the
// FSM is outside IDLE.
//
// Optional feature: define DMEM_ZERO_INIT_EN to add an INIT state after reset
// that writes zero to every word (ascending order, one word per cycle).
module dmem_responder #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CEN,
  input  logic        WEN,
  input  logic        OEN,
  input  logic [6:0]  A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        ready,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Encodings are fixed so dbg_state means the same thing in every build.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
`ifdef DMEM_ZERO_INIT_EN
    , S_INIT = 2'd3
`endif
  } state_t;

  // Counter reload value; unused when LATENCY is 0 since WAIT is skipped.
  localparam logic [2:0] WAIT_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t      state;
  logic [2:0]  cnt;
  logic [6:0]  cap_a;
  logic [31:0] cap_d;
  logic        cap_wen;
  logic [31:0] q_reg;
  logic [31:0] mem [128];

`ifdef DMEM_ZERO_INIT_EN
  logic [6:0]  init_idx;
`endif

  // Array access for the edge entering RESP. With zero latency the capture
  // and the access share one edge, so the live inputs are used directly.
  logic        op_go;
  logic        op_read;
  logic [6:0]  op_addr;
  logic [31:0] op_data;

  // Select the operand source for the access happening at the next edge.
  always_comb begin
    op_go   = 1'b0;
    op_read = 1'b0;
    op_addr = cap_a;
    op_data = cap_d;
    if (state == S_IDLE && !CEN && LATENCY == 0) begin
      op_go   = 1'b1;
      op_read = WEN;
      op_addr = A;
      op_data = D;
    end else if (state == S_WAIT && cnt == 3'd0) begin
      op_go   = 1'b1;
      op_read = cap_wen;
    end
  end

  // Array write port. Gating with rst_n guarantees that a reset edge never
  // commits a pending write; the zero-fill sweep shares the same port.
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;

  // Choose between the protocol write and the zero-fill sweep.
  always_comb begin
    mem_we    = rst_n && op_go && !op_read;
    mem_addr  = op_addr;
    mem_wdata = op_data;
`ifdef DMEM_ZERO_INIT_EN
    if (state == S_INIT) begin
      mem_we    = rst_n;
      mem_addr  = init_idx;
      mem_wdata = 32'h0;
    end
`endif
  end

  // Storage array; intentionally not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Protocol FSM with registered ready and output data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef DMEM_ZERO_INIT_EN
      state    <= S_INIT;
      init_idx <= 7'd0;
`else
      state    <= S_IDLE;
`endif
      cnt      <= 3'd0;
      q_reg    <= 32'h0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      // The output register only changes when a read completes.
      if (op_go && op_read) begin
        q_reg <= mem[op_addr];
      end
      case (state)
`ifdef DMEM_ZERO_INIT_EN
        S_INIT: begin
          init_idx <= init_idx + 7'd1;
          if (init_idx == 7'd127) begin
            state <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
          if (!CEN) begin
            cap_a   <= A;
            cap_d   <= D;
            cap_wen <= WEN;
            if (LATENCY == 0) begin
              state <= S_RESP;
              ready <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state <= S_RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign Q         = OEN ? 32'h0 : q_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Four instances share clock and reset:
// index 0 -> LATENCY 1, 1 -> LATENCY 0, 2 -> LATENCY 7, 3 -> LATENCY 3.
// Honours DMEM_ZERO_INIT_EN when the bench is built with it defined.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        cen [4];
  logic        wen [4];
  logic        oen [4];
  logic [6:0]  a   [4];
  logic [31:0] d   [4];
  logic [31:0] q   [4];
  logic        ready [4];
  logic        busy  [4];
  logic [1:0]  st    [4];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 3;
    dmem_responder #(.LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .CEN       (cen[g]),
      .WEN       (wen[g]),
      .OEN       (oen[g]),
      .A         (a[g]),
      .D         (d[g]),
      .Q         (q[g]),
      .ready     (ready[g]),
      .busy      (busy[g]),
      .dbg_state (st[g])
    );
  end

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction: capture, LATENCY wait cycles, one ready cycle, idle.
  task automatic xact(input int i, input logic rd, input logic [6:0] addr,
                      input logic [31:0] data, input int lat,
                      input logic [31:0] exp_q, input string tag);
    cen[i] = 1'b0; wen[i] = rd; a[i] = addr; d[i] = data;
    step();
    cen[i] = 1'b1;
    for (int c = 0; c < lat; c++) begin
      chk({tag, "_early_ready"}, 32'(ready[i]), 32'd0);
      chk({tag, "_wait_busy"}, 32'(busy[i]), 32'd1);
      step();
    end
    chk({tag, "_ready"}, 32'(ready[i]), 32'd1);
    chk({tag, "_resp_busy"}, 32'(busy[i]), 32'd1);
    if (rd) chk({tag, "_q_resp"}, q[i], exp_q);
    step();
    chk({tag, "_ready_drop"}, 32'(ready[i]), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy[i]), 32'd0);
    if (rd) chk({tag, "_q_hold"}, q[i], exp_q);
  endtask

  // After reset release: wait out the zero-fill sweep if it is built in.
  task automatic wait_init();
`ifdef DMEM_ZERO_INIT_EN
    for (int j = 0; j < 128; j++) begin
      chk("init_busy", 32'(busy[0]), 32'd1);
      step();
    end
    chk("init_done", 32'(busy[0]), 32'd0);
`else
    step();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cen[i] = 1'b1; wen[i] = 1'b1; oen[i] = 1'b0; a[i] = 7'd0; d[i] = 32'h0;
    end
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_ready", 32'(ready[i]), 32'd0);
      chk("rst_q", q[i], 32'h0);
`ifdef DMEM_ZERO_INIT_EN
      chk("rst_busy", 32'(busy[i]), 32'd1);
`else
      chk("rst_busy", 32'(busy[i]), 32'd0);
`endif
    end
    rst_n = 1'b1;
    wait_init();

    // LATENCY 1: write then read back
    xact(0, 1'b0, 7'd5, 32'hDEADBEEF, 1, 32'h0, "l1_wr5");
    xact(0, 1'b1, 7'd5, 32'h0, 1, 32'hDEADBEEF, "l1_rd5");

    // LATENCY 0 and 7: ready timing and busy window
    xact(1, 1'b0, 7'd10, 32'h0A0A0A0A, 0, 32'h0, "l0_wr");
    xact(1, 1'b1, 7'd10, 32'h0, 0, 32'h0A0A0A0A, "l0_rd");
    xact(2, 1'b0, 7'd11, 32'h0B0B0B0B, 7, 32'h0, "l7_wr");
    xact(2, 1'b1, 7'd11, 32'h0, 7, 32'h0B0B0B0B, "l7_rd");
    xact(2, 1'b0, 7'd127, 32'h7F7F7F7F, 7, 32'h0, "l7_wr127");
    xact(2, 1'b1, 7'd127, 32'h0, 7, 32'h7F7F7F7F, "l7_rd127");

    // OEN gating and output register hold across a write
    xact(0, 1'b0, 7'd3, 32'h12345678, 1, 32'h0, "oe_wr3");
    xact(0, 1'b1, 7'd3, 32'h0, 1, 32'h12345678, "oe_rd3");
    oen[0] = 1'b1; #1;
    chk("oen_high_q", q[0], 32'h0);
    oen[0] = 1'b0; #1;
    chk("oen_low_q", q[0], 32'h12345678);
    xact(0, 1'b0, 7'd3, 32'hBBBB0003, 1, 32'h0, "oe_wr3b");
    chk("q_after_write", q[0], 32'h12345678);
    xact(0, 1'b1, 7'd3, 32'h0, 1, 32'hBBBB0003, "raw_rd3");

    // LATENCY 3: reset in the second WAIT cycle aborts a pending write
    xact(3, 1'b0, 7'd9, 32'hCAFE0009, 3, 32'h0, "l3_pre9");
    cen[3] = 1'b0; wen[3] = 1'b0; a[3] = 7'd9; d[3] = 32'h1;
    step();
    cen[3] = 1'b1;
    chk("abort_wait1_busy", 32'(busy[3]), 32'd1);
    step();
    chk("abort_wait2_busy", 32'(busy[3]), 32'd1);
    rst_n = 1'b0;
    step();
    chk("abort_rst_ready", 32'(ready[3]), 32'd0);
    rst_n = 1'b1;
    wait_init();
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_ready", 32'(ready[3]), 32'd0);
      step();
    end
`ifdef DMEM_ZERO_INIT_EN
    xact(3, 1'b1, 7'd9, 32'h0, 3, 32'h0, "abort_rd9");
`else
    xact(3, 1'b1, 7'd9, 32'h0, 3, 32'hCAFE0009, "abort_rd9");
`endif

    // LATENCY 3: CEN low in WAIT with a different address is ignored
    xact(3, 1'b0, 7'd20, 32'h20202020, 3, 32'h0, "ign_wr20");
    xact(3, 1'b0, 7'd21, 32'h21212121, 3, 32'h0, "ign_wr21");
    cen[3] = 1'b0; wen[3] = 1'b1; a[3] = 7'd20;
    step();
    a[3] = 7'd21;
    for (int c = 0; c < 3; c++) begin
      chk("ign_no_ready", 32'(ready[3]), 32'd0);
      step();
    end
    chk("ign_ready", 32'(ready[3]), 32'd1);
    chk("ign_q", q[3], 32'h20202020);
    cen[3] = 1'b1;
    step();
    chk("ign_idle_busy", 32'(busy[3]), 32'd0);
    step();
    chk("ign_no_second", 32'(busy[3]), 32'd0);
    chk("ign_q_hold", q[3], 32'h20202020);

`ifdef DMEM_ZERO_INIT_EN
    // Zero-fill: pre-fill, reset, CEN held low during the sweep, then read 0
    xact(0, 1'b0, 7'd0, 32'hFFFFFFFF, 1, 32'h0, "zf_pre0");
    xact(0, 1'b0, 7'd64, 32'hFFFFFFFF, 1, 32'h0, "zf_pre64");
    xact(0, 1'b0, 7'd127, 32'hFFFFFFFF, 1, 32'h0, "zf_pre127");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cen[0] = 1'b0; wen[0] = 1'b1; a[0] = 7'd0;
    for (int j = 0; j < 128; j++) begin
      chk("zf_busy", 32'(busy[0]), 32'd1);
      chk("zf_no_ready", 32'(ready[0]), 32'd0);
      if (j == 127) cen[0] = 1'b1;
      step();
    end
    chk("zf_idle", 32'(busy[0]), 32'd0);
    xact(0, 1'b1, 7'd0, 32'h0, 1, 32'h0, "zf_rd0");
    xact(0, 1'b1, 7'd64, 32'h0, 1, 32'h0, "zf_rd64");
    xact(0, 1'b1, 7'd127, 32'h0, 1, 32'h0, "zf_rd127");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
